// File: rtl/mc_controller_hs.sv
// Multicycle control FSM for the accumulator CPU datapath.
// Drives a req/ack memory with wait states and has a watchdog that parks it in ERR.
module mc_controller_hs #(
    parameter int ACC_SEL_W = 2,
    parameter int ALU_OP_W  = 2,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           ir_op,
    input  logic [2:0]           ir_lo,
    input  logic [2:0]           czn,
    input  logic                 mem_ack,
    output logic                 done,
    output logic                 err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 pc_inc,
    output logic                 pc_ld,
    output logic                 ir_we,
    output logic                 tr_we,
    output logic                 a_we,
    output logic                 b_we,
    output logic                 b_src,
    output logic                 a_zero,
    output logic                 b_zero,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 alu_we,
    output logic                 czn_we,
    output logic [ACC_SEL_W-1:0] acc_sel,
    output logic                 acc_we
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [ALU_OP_W-1:0]  OP_ADD = '0;
    localparam logic [ALU_OP_W-1:0]  OP_AND = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0]  OP_NOT = ALU_OP_W'(2);
    localparam logic [ACC_SEL_W-1:0] ASEL_1 = ACC_SEL_W'(1);
    localparam logic [ACC_SEL_W-1:0] ASEL_2 = ACC_SEL_W'(2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_BRANCH,
        S_LDOPS,
        S_CALC16,
        S_WB16,
        S_LDACC,
        S_CALC,
        S_WRACC,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic op_mem;
    logic op_br;
    logic op_nop;
    logic op_halt;
    logic op_acc;
    logic op_sta;
    logic br_take;
    logic wd_exp;
    logic unused_lo;

    assign op_br     = (ir_op[3:1] == 3'b110);
    assign op_mem    = !ir_op[3] || op_br;
    assign op_nop    = (ir_op == 4'b1110);
    assign op_halt   = (ir_op == 4'b1111);
    assign op_acc    = (ir_op[3:2] == 2'b10);
    assign op_sta    = (ir_op[2:1] == 2'b01);
    assign unused_lo = ir_lo[0];

    // Last permitted wait cycle: no ack now means the access is abandoned.
    assign wd_exp = (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_comb begin
        br_take = 1'b0;
        unique case (ir_lo[2:1])
            2'b00: br_take = 1'b1;
            2'b01: br_take = czn[2];
            2'b10: br_take = czn[1];
            2'b11: br_take = czn[0];
            default: br_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        err      = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        ir_we    = 1'b0;
        tr_we    = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        b_src    = 1'b0;
        a_zero   = 1'b0;
        b_zero   = 1'b0;
        alu_op   = OP_ADD;
        alu_we   = 1'b0;
        czn_we   = 1'b0;
        acc_sel  = '0;
        acc_we   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                done = 1'b1;
                if (start) state_d = S_START;
            end
            S_START: begin
                if (!start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_exp) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    op_mem:  state_d = S_OPND;
                    op_nop:  state_d = S_FETCH;
                    op_halt: state_d = S_IDLE;
                    op_acc: begin
                        acc_sel = ASEL_1;
                        b_we    = 1'b1;
                        state_d = S_LDACC;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_OPND: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    tr_we   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = op_br ? S_BRANCH : S_LDOPS;
                end else if (wd_exp) begin
                    state_d = S_ERR;
                end
            end
            S_BRANCH: begin
                pc_ld   = br_take;
                state_d = S_FETCH;
            end
            S_LDOPS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    b_src   = 1'b1;
                    b_we    = 1'b1;
                    a_we    = 1'b1;
                    acc_sel = ASEL_1;
                    state_d = S_CALC16;
                end else if (wd_exp) begin
                    state_d = S_ERR;
                end
            end
            S_CALC16: begin
                alu_we = 1'b1;
                unique case (ir_op[2:1])
                    2'b00: begin
                        a_zero = 1'b1;
                        czn_we = 1'b1;
                    end
                    2'b01: b_zero = 1'b1;
                    2'b10: czn_we = 1'b1;
                    2'b11: begin
                        czn_we = 1'b1;
                        alu_op = OP_AND;
                    end
                    default: alu_op = OP_ADD;
                endcase
                state_d = S_WB16;
            end
            S_WB16: begin
                if (op_sta) begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ack) begin
                        state_d = S_FETCH;
                    end else if (wd_exp) begin
                        state_d = S_ERR;
                    end
                end else begin
                    acc_we  = 1'b1;
                    acc_sel = ASEL_1;
                    state_d = S_FETCH;
                end
            end
            S_LDACC: begin
                acc_sel = ASEL_2;
                a_we    = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                alu_we = 1'b1;
                unique case (ir_op[1:0])
                    2'b00: b_zero = 1'b1;
                    2'b01: czn_we = 1'b1;
                    2'b10: begin
                        czn_we = 1'b1;
                        alu_op = OP_AND;
                    end
                    2'b11: begin
                        czn_we = 1'b1;
                        alu_op = OP_NOT;
                    end
                    default: alu_op = OP_ADD;
                endcase
                state_d = S_WRACC;
            end
            S_WRACC: begin
                acc_sel = ASEL_1;
                acc_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                err  = 1'b1;
                done = 1'b1;
                if (start) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase

        // Counts unacknowledged cycles of the current access only.
        cnt_d = (mem_req && !mem_ack) ? cnt_q + CNT_W'(1) : '0;
    end

endmodule
